// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sweeps a registered-read BRAM once per Start and streams it out with valid/ready backpressure
`timescale 1ns/1ps
module bram_stream_reader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 6,
  parameter int BITREV     = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  output logic                  Bram_En,
  output logic                  Bram_We,
  output logic [DEPTH_LOG2-1:0] Bram_Addr,
  input  logic [WIDTH-1:0]      Bram_DO,
  output logic [WIDTH-1:0]      Dout,
  output logic                  Dout_Valid,
  input  logic                  Dout_Ready,
  output logic                  Dout_Last,
  output logic                  Busy,
  output logic                  Done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [DEPTH_LOG2-1:0] cnt, addr_q, rev, cur;
  logic f, f_last, pop, issue, l0, l1, sh_l;
  logic [1:0] occ, occ_rem;
  logic [WIDTH-1:0] d0, d1, sh_d;
  genvar i;
  generate
    for (i = 0; i < DEPTH_LOG2; i++) begin : g_rev
      assign rev[i] = cnt[DEPTH_LOG2-1-i];
    end
  endgenerate
  assign cur        = BITREV != 0 ? rev : cnt;
  assign Dout_Valid = |occ;
  assign pop        = Dout_Valid & Dout_Ready;
  // buffered + in-flight words may never exceed the two FIFO slots
  assign issue      = state == RUN && ({1'b0, occ} + {2'b0, f}) < (3'd2 + {2'b0, pop});
  assign Bram_En    = issue;
  assign Bram_We    = 1'b0;
  assign Bram_Addr  = issue ? cur : addr_q;
  assign Dout       = d0;
  assign Dout_Last  = l0 & Dout_Valid;
  assign Busy       = state != IDLE;
  assign occ_rem    = occ - {1'b0, pop};
  assign sh_d       = pop ? d1 : d0;
  assign sh_l       = pop ? l1 : l0;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      f      <= 1'b0;
      f_last <= 1'b0;
      occ    <= '0;
      d0     <= '0;
      d1     <= '0;
      l0     <= 1'b0;
      l1     <= 1'b0;
      Done   <= 1'b0;
    end else begin
      if (issue) begin
        cnt    <= cnt + 1'b1;
        addr_q <= cur;
      end
      f      <= issue;
      f_last <= issue && cnt == '1;
      occ    <= occ_rem + {1'b0, f};
      d0     <= (f && occ_rem == 2'd0) ? Bram_DO : sh_d;
      l0     <= (f && occ_rem == 2'd0) ? f_last : sh_l;
      d1     <= (f && occ_rem == 2'd1) ? Bram_DO : d1;
      l1     <= (f && occ_rem == 2'd1) ? f_last : l1;
      Done   <= state == DRAIN && pop && Dout_Last;
      state  <= state == IDLE ? (Start ? RUN : IDLE) :
                state == RUN  ? ((issue && cnt == '1) ? DRAIN : RUN) :
                ((pop && Dout_Last) ? IDLE : DRAIN);
    end
  end
endmodule
